// File: rtl/xform_pkg.sv
// rtl/xform_pkg.sv - mode constants and output width helper for the 4-sample transform
package xform_pkg;

    localparam logic [1:0] MODE_PAIR = 2'd0;
    localparam logic [1:0] MODE_HAD  = 2'd1;
    localparam logic [1:0] MODE_PASS = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // Two guard bits cover the worst-case four-term Hadamard sum.
    function automatic int out_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/xform4_core.sv
// rtl/xform4_core.sv - combinational pair / Hadamard / pass-through transform of four samples
module xform4_core
    import xform_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] x2,
    input  logic signed [WIDTH-1:0] x3,
    input  logic        [1:0]       mode,
    output logic signed [WIDTH+1:0] y0,
    output logic signed [WIDTH+1:0] y1,
    output logic signed [WIDTH+1:0] y2,
    output logic signed [WIDTH+1:0] y3
);

    localparam int OW = out_width(WIDTH);

    logic signed [OW-1:0] a0, a1, a2, a3;

    always_comb begin
        a0 = OW'(x0);
        a1 = OW'(x1);
        a2 = OW'(x2);
        a3 = OW'(x3);
        y0 = a0;
        y1 = a1;
        y2 = a2;
        y3 = a3;
        case (mode)
            MODE_PAIR: begin
                y0 = a0 + a1;
                y1 = a0 - a1;
                y2 = a2 + a3;
                y3 = a2 - a3;
            end
            MODE_HAD: begin
                y0 = a0 + a1 + a2 + a3;
                y1 = a0 - a1 + a2 - a3;
                y2 = a0 + a1 - a2 - a3;
                y3 = a0 - a1 - a2 + a3;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stream_xform4.sv
// rtl/stream_xform4.sv - frames four input samples, transforms them and serializes the results
module stream_xform4
    import xform_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic        [1:0]       mode,
    output logic signed [WIDTH+1:0] out,
    output logic                    out_valid,
    output logic                    frame_err
);

    localparam int OW = out_width(WIDTH);

    logic        [1:0]       cnt_q, cnt_d;
    logic signed [WIDTH-1:0] x_q [4];
    logic signed [WIDTH-1:0] x_d [4];
    logic        [1:0]       frame_mode_q, frame_mode_d;
    logic                    load_q, load_d;
    logic signed [OW-1:0]    bank_q [4];
    logic signed [OW-1:0]    bank_d [4];
    logic        [1:0]       remain_q, remain_d;
    logic signed [OW-1:0]    out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic signed [OW-1:0]    y [4];
    logic        [1:0]       emit_idx;

    xform4_core #(.WIDTH(WIDTH)) u_core (
        .x0   (x_q[0]),
        .x1   (x_q[1]),
        .x2   (x_q[2]),
        .x3   (x_q[3]),
        .mode (frame_mode_q),
        .y0   (y[0]),
        .y1   (y[1]),
        .y2   (y[2]),
        .y3   (y[3])
    );

    // remain 3,2,1 selects bank entries 1,2,3
    assign emit_idx = 2'd0 - remain_q;

    always_comb begin
        cnt_d        = cnt_q;
        x_d          = x_q;
        frame_mode_d = frame_mode_q;
        load_d       = 1'b0;
        frame_err_d  = 1'b0;
        if (in_valid) begin
            if (in_sof && cnt_q != 2'd0) begin
                x_d[0]       = in;
                frame_mode_d = mode;
                cnt_d        = 2'd1;
                frame_err_d  = 1'b1;
            end else begin
                x_d[cnt_q] = in;
                if (cnt_q == 2'd0) frame_mode_d = mode;
                if (cnt_q == 2'd3) load_d = 1'b1;
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    // y0 goes straight to the output on the load edge so frames abut without a gap
    always_comb begin
        bank_d      = bank_q;
        remain_d    = remain_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (load_q) begin
            bank_d      = y;
            out_d       = y[0];
            out_valid_d = 1'b1;
            remain_d    = 2'd3;
        end else if (remain_q != 2'd0) begin
            out_d       = bank_q[emit_idx];
            out_valid_d = 1'b1;
            remain_d    = remain_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            x_q          <= '{default: '0};
            frame_mode_q <= MODE_PAIR;
            load_q       <= 1'b0;
            bank_q       <= '{default: '0};
            remain_q     <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            frame_mode_q <= frame_mode_d;
            load_q       <= load_d;
            bank_q       <= bank_d;
            remain_q     <= remain_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_stream_xform4.sv
// tb/tb_stream_xform4.sv - scoreboard bench for stream_xform4 with directed frames
module tb_stream_xform4;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] in_s;
    logic              in_valid;
    logic              in_sof;
    logic        [1:0] mode;
    logic signed [9:0] out;
    logic              out_valid;
    logic              frame_err;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int cyc = 0;
    int run = 0;
    int last_run = 0;
    int run_start = 0;
    int err_cnt = 0;
    int x3_cyc = 0;

    stream_xform4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_s),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .mode      (mode),
        .out       (out),
        .out_valid (out_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (out_valid) begin
            if (run == 0) run_start = cyc;
            run++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %0d, expected no output", out);
            end else begin
                check("out_value", int'(out), exp_q.pop_front());
            end
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic send(input int v, input logic sof, input logic [1:0] m);
        in_s     = 8'(v);
        in_sof   = sof;
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int a, input int b, input int c, input int d, input logic [1:0] m);
        send(a, 1'b1, m);
        send(b, 1'b0, m);
        send(c, 1'b0, m);
        send(d, 1'b0, m);
        x3_cyc = cyc;
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || run != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, exp_q.size() + run, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_s     = '0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        mode     = 2'd0;
        idle(2);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_out", int'(out), 0);
            check("idle_valid", int'(out_valid), 0);
            check("idle_err", int'(frame_err), 0);
        end
        #1;

        // Hadamard 1,2,3,4
        push4(10, -2, -4, 0);
        frame(1, 2, 3, 4, 2'd1);
        drain("had");
        check("had_run_len", last_run, 4);
        check("had_latency", run_start, x3_cyc + 1);

        // pair mode, two back-to-back frames
        push4(8, 2, 119, -135);
        push4(8, 2, 119, -135);
        frame(5, 3, -8, 127, 2'd0);
        frame(5, 3, -8, 127, 2'd0);
        drain("pair");
        check("pair_run_len", last_run, 8);

        // Hadamard extremes
        push4(-512, 0, 0, 0);
        push4(508, 0, 0, 0);
        frame(-128, -128, -128, -128, 2'd1);
        frame(127, 127, 127, 127, 2'd1);
        drain("extreme");

        // gapped pass-through, mode flip after x0 ignored
        push4(9, 7, 6, 5);
        send(9, 1'b1, 2'd2);
        idle(2);
        send(7, 1'b0, 2'd1);
        idle(1);
        send(6, 1'b0, 2'd1);
        send(5, 1'b0, 2'd1);
        x3_cyc = cyc;
        drain("gapped");
        check("gapped_latency", run_start, x3_cyc + 1);
        check("no_err_yet", err_cnt, 0);

        // resync drops the partial frame 1,2
        push4(30, -10, 70, -10);
        send(1, 1'b1, 2'd0);
        send(2, 1'b0, 2'd0);
        frame(10, 20, 30, 40, 2'd0);
        drain("resync");
        check("resync_err_pulses", err_cnt, 1);

        // reset between y1 and y2 drops the rest
        exp_q.push_back(30);
        exp_q.push_back(-10);
        frame(10, 20, 30, 40, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_out", int'(out), 0);
        #1;
        idle(10);
        check("reset_queue_empty", exp_q.size(), 0);
        check("reset_err_pulses", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
